rsa_key_gen: RTL and testbench

//  Sequential RSA key generator for small primes. Latches primes p and q on start, then computes:
//    n   = p*q
//    phi = (p-1)*(q-1)
//    e   = smallest odd value >= 3 with gcd(e,phi)=1
//    d   = e^-1 mod phi

---
 rtl/rsa_key_gen.sv | 133 +++++++++++++
 tb/tb_rsa_key_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rsa_key_gen.sv
// Sequential small-prime RSA key generator: n, phi, smallest coprime odd e, and d = e^-1 mod phi.
// Optional KEYGEN_ERR_EN adds an error flag raised with finish whenever no key could be formed (e=0).
module rsa_key_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  p,
  input  logic [7:0]  q,
  output logic [7:0]  e,
  output logic [15:0] d,
  output logic [15:0] n,
  output logic        finish
`ifdef KEYGEN_ERR_EN
  ,
  output logic        error
`endif
);

  typedef enum logic [2:0] {IDLE, MUL, GCD, INV, DONE} state_t;

  state_t      state;
  logic [7:0]  p_r, q_r;
  logic [15:0] phi, ga, gb, acc, emod, dcnt;
  logic [8:0]  cand;

  logic [7:0]  p1, q1;
  logic [15:0] phi_c, rem, emod_c, acc_nx;
  logic [16:0] sum;
  logic [8:0]  cand_nx;
  logic        degen;

  always_comb begin
    p1      = p_r - 8'd1;
    q1      = q_r - 8'd1;
    phi_c   = {8'd0, p1} * {8'd0, q1};
    degen   = (p_r == 8'd0) || (q_r == 8'd0) || (phi_c < 16'd3);
    rem     = (gb == 16'd0) ? 16'd0 : ga % gb;
    cand_nx = cand + 9'd2;
    emod_c  = (phi == 16'd0) ? 16'd0 : {7'd0, cand} % phi;
    // acc and emod are both < phi, so one conditional subtract keeps the sum reduced
    sum     = {1'b0, acc} + {1'b0, emod};
    acc_nx  = (sum >= {1'b0, phi}) ? 16'(sum - {1'b0, phi}) : sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      e      <= '0;
      d      <= '0;
      n      <= '0;
      finish <= 1'b0;
      p_r    <= '0;
      q_r    <= '0;
      phi    <= '0;
      ga     <= '0;
      gb     <= '0;
      acc    <= '0;
      emod   <= '0;
      dcnt   <= '0;
      cand   <= '0;
    end else begin
      finish <= 1'b0;
      case (state)
        IDLE: if (start) begin
          p_r   <= p;
          q_r   <= q;
          state <= MUL;
        end
        MUL: begin
          n   <= {8'd0, p_r} * {8'd0, q_r};
          phi <= phi_c;
          if (degen) begin
            e      <= '0;
            d      <= '0;
            finish <= 1'b1;
            state  <= DONE;
          end else begin
            ga    <= phi_c;
            gb    <= 16'd3;
            cand  <= 9'd3;
            state <= GCD;
          end
        end
        GCD: begin
          if (gb != 16'd0) begin
            ga <= gb;
            gb <= rem;
          end else if (ga == 16'd1) begin
            acc   <= emod_c;
            emod  <= emod_c;
            dcnt  <= 16'd1;
            state <= INV;
          end else if (cand_nx > 9'd255) begin
            e      <= '0;
            d      <= '0;
            finish <= 1'b1;
            state  <= DONE;
          end else begin
            cand <= cand_nx;
            ga   <= phi;
            gb   <= {7'd0, cand_nx};
          end
        end
        INV: begin
          if (acc == 16'd1) begin
            e      <= cand[7:0];
            d      <= dcnt;
            finish <= 1'b1;
            state  <= DONE;
          end else begin
            acc  <= acc_nx;
            dcnt <= dcnt + 16'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef KEYGEN_ERR_EN
  logic fail_c;
  assign fail_c = ((state == MUL) && degen) ||
                  ((state == GCD) && (gb == 16'd0) && (ga != 16'd1) && (cand_nx > 9'd255));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      error <= 1'b0;
    else if (state == IDLE && start) error <= 1'b0;
    else if (fail_c)                 error <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_rsa_key_gen.sv
// Scoreboard bench for rsa_key_gen: expected keys come from a brute-force reference model.
module tb_rsa_key_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  p = '0, q = '0;
  logic [7:0]  e;
  logic [15:0] d, n;
  logic        finish;
`ifdef KEYGEN_ERR_EN
  logic        error;
`endif

  rsa_key_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .p(p), .q(q),
    .e(e), .d(d), .n(n), .finish(finish)
`ifdef KEYGEN_ERR_EN
    , .error(error)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  e;
    logic [15:0] d;
    logic [15:0] n;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   fin_cnt = 0;

  always @(negedge clk) if (finish === 1'b1) fin_cnt++;

  function automatic exp_t model(input logic [7:0] pp, input logic [7:0] qq);
    exp_t r;
    int ph, ee, dd, a, b, t;
    r.n = 16'(int'(pp) * int'(qq));
    r.e = '0; r.d = '0; r.err = 1'b1;
    ph = (int'(pp) - 1) * (int'(qq) - 1);
    if (pp == 0 || qq == 0 || ph < 3) return r;
    for (ee = 3; ee <= 255; ee += 2) begin
      a = ph; b = ee;
      while (b != 0) begin t = a % b; a = b; b = t; end
      if (a == 1) break;
    end
    if (ee > 255) return r;
    for (dd = 1; dd < ph; dd++) if ((ee * dd) % ph == 1) break;
    r.e = 8'(ee); r.d = 16'(dd); r.err = 1'b0;
    return r;
  endfunction

  task automatic drive_start(input logic [7:0] pp, input logic [7:0] qq, input bit push);
    @(negedge clk);
    p = pp; q = qq; start = 1'b1;
    if (push) sb.push_back(model(pp, qq));
    @(negedge clk);
    start = 1'b0; p = 8'($urandom); q = 8'($urandom);
  endtask

  task automatic wait_fin(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200000; i++) begin
      @(negedge clk);
      if (finish === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++;
    if ({e, d, n, finish} !== 41'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {e, d, n, finish});
    end
`ifdef KEYGEN_ERR_EN
    total++;
    if (error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", error); end
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_key(input logic [7:0] pp, input logic [7:0] qq,
                          input logic [39:0] lit, input bit use_lit);
    bit ok; exp_t w; int f0;
    f0 = fin_cnt;
    drive_start(pp, qq, 1'b1);
    wait_fin(ok);
    w = sb.pop_front();
    total++;
    if (!ok) begin
      bad++; $display("FAIL key_timeout p=%0d q=%0d got=no finish want=finish", pp, qq);
    end else begin
      if ({e, d, n} !== {w.e, w.d, w.n}) begin
        bad++; $display("FAIL key p=%0d q=%0d got e=%0d d=%0d n=%0d want e=%0d d=%0d n=%0d",
                        pp, qq, e, d, n, w.e, w.d, w.n);
      end
`ifdef KEYGEN_ERR_EN
      total++;
      if (error !== w.err) begin
        bad++; $display("FAIL key_error p=%0d q=%0d got=%b want=%b", pp, qq, error, w.err);
      end
`endif
    end
    if (use_lit) begin
      total++;
      if ({e, d, n} !== lit) begin
        bad++; $display("FAIL key_literal p=%0d q=%0d got=%h want=%h", pp, qq, {e, d, n}, lit);
      end
    end
    repeat (3) @(negedge clk);
    total++;
    if (fin_cnt !== f0 + 1) begin
      bad++; $display("FAIL finish_count p=%0d q=%0d got=%0d want=%0d", pp, qq, fin_cnt - f0, 1);
    end
  endtask

  task automatic test_busy;
    bit ok; exp_t w; int f0;
    f0 = fin_cnt;
    drive_start(8'd11, 8'd13, 1'b1);
    repeat (4) @(negedge clk);
    drive_start(8'd53, 8'd59, 1'b0);
    repeat (20) @(negedge clk);
    drive_start(8'd61, 8'd53, 1'b0);
    wait_fin(ok);
    w = sb.pop_front();
    total++;
    if (!ok || {e, d, n} !== {w.e, w.d, w.n} || {e, d, n} !== {8'd7, 16'd103, 16'd143}) begin
      bad++; $display("FAIL busy_ignore got ok=%0d e=%0d d=%0d n=%0d want e=7 d=103 n=143",
                      ok, e, d, n);
    end
    repeat (30) @(negedge clk);
    total++;
    if (fin_cnt !== f0 + 1 || {e, d, n} !== {8'd7, 16'd103, 16'd143}) begin
      bad++; $display("FAIL busy_single_finish got finishes=%0d e=%0d d=%0d n=%0d want 1 7 103 143",
                      fin_cnt - f0, e, d, n);
    end
  endtask

  task automatic test_reset_mid;
    int f0;
    f0 = fin_cnt;
    drive_start(8'd53, 8'd59, 1'b1);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    total++;
    if ({e, d, n, finish} !== 41'd0) begin
      bad++; $display("FAIL reset_mid_outputs got=%h want=0", {e, d, n, finish});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2500) @(negedge clk);
    total++;
    if (fin_cnt !== f0 || n !== 16'd0) begin
      bad++; $display("FAIL reset_mid_no_finish got finishes=%0d n=%0d want 0 0", fin_cnt - f0, n);
    end
    test_key(8'd53, 8'd59, {8'd3, 16'd2011, 16'd3127}, 1'b1);
  endtask

  task automatic test_hold;
    logic [39:0] snap; bit moved; int f0;
    snap = {e, d, n}; moved = 1'b0; f0 = fin_cnt;
    repeat (100) begin
      @(negedge clk);
      if ({e, d, n} !== snap || finish !== 1'b0) moved = 1'b1;
    end
    total++;
    if (moved || fin_cnt !== f0) begin
      bad++; $display("FAIL hold got moved=%0d finishes=%0d want 0 0", moved, fin_cnt - f0);
    end
  endtask

  initial begin
    test_reset();
    test_key(8'd53, 8'd59, {8'd3, 16'd2011, 16'd3127}, 1'b1);
    test_key(8'd61, 8'd53, {8'd7, 16'd1783, 16'd3233}, 1'b1);
    test_busy();
    test_key(8'd1, 8'd13, {8'd0, 16'd0, 16'd13}, 1'b1);
    test_key(8'd0, 8'd7, {8'd0, 16'd0, 16'd0}, 1'b1);
    test_key(8'd3, 8'd5, 40'd0, 1'b0);
    test_key(8'd17, 8'd19, 40'd0, 1'b0);
    test_key(8'd101, 8'd103, 40'd0, 1'b0);
    test_key(8'd255, 8'd255, {8'd3, 16'd43011, 16'd65025}, 1'b1);
    test_reset_mid();
    test_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
